// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the shared-memory port arbiter: FSM state type,
// default sizing constants and the owner-index width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Defaults kept alongside the pool-wide sizing constants.
    localparam int unsigned DEFAULT_PORT_COUNT = 4;
    localparam int unsigned DEFAULT_MAX_HOLD   = 16;

    // Hold counter width; covers the full MAX_HOLD range of 2..255.
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } arb_state_e;

    // Owner index width, never narrower than one bit so a single-port build
    // still has a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_rr_select
// Combinational round-robin priority scan: returns the first set request
// starting at the pointer and scanning upward, wrapping modulo N.
// Ports:
//   i_req    [N-1:0]      request vector
//   i_ptr    [IDX_W-1:0]  scan start position (must be < N)
//   o_found               any request set
//   o_idx    [IDX_W-1:0]  selected position (0 when nothing found)
// -----------------------------------------------------------------------------
module mem_port_arbiter_rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Two passes avoid modular arithmetic: first the positions at or above the
    // pointer, then the wrapped positions below it.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (!o_found && i_req[p] && (IDX_W'(p) >= i_ptr)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(p);
            end
        end
        for (int unsigned p = 0; p < N; p++) begin
            if (!o_found && i_req[p]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter for the single shared-memory access port. Grants one
// processor at a time (write wins over read on the same port), bounds the hold
// time while others wait, and inserts a one-cycle turnaround gap between owners.
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_req_rd [PORT_COUNT]    per-port read request (level, held until done)
//   i_req_wr [PORT_COUNT]    per-port write request (level, held until done)
//   o_grant_rd [PORT_COUNT]  one-hot registered read grant
//   o_grant_wr [PORT_COUNT]  one-hot registered write grant
//   o_grant_valid            any grant active
//   o_grant_idx [IDX_W]      current owner; meaningful only with o_grant_valid
//   o_preempt                one-cycle pulse when a grant is removed by timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned PORT_COUNT = DEFAULT_PORT_COUNT,
    parameter int unsigned MAX_HOLD   = DEFAULT_MAX_HOLD,
    parameter int unsigned IDX_W      = idx_width(PORT_COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [PORT_COUNT-1:0] i_req_rd,
    input  logic [PORT_COUNT-1:0] i_req_wr,
    output logic [PORT_COUNT-1:0] o_grant_rd,
    output logic [PORT_COUNT-1:0] o_grant_wr,
    output logic                  o_grant_valid,
    output logic [IDX_W-1:0]      o_grant_idx,
    output logic                  o_preempt
);

    arb_state_e              r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [HOLD_W-1:0]       r_hold;
    logic [PORT_COUNT-1:0]   r_grant_rd;
    logic [PORT_COUNT-1:0]   r_grant_wr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic                    r_owner_wr;
    logic                    r_preempt;

    logic [PORT_COUNT-1:0]   w_elig;
    logic                    w_found;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [PORT_COUNT-1:0]   w_sel_mask;
    logic                    w_sel_wr;
    logic [PORT_COUNT-1:0]   w_owner_mask;
    logic                    w_owner_req;
    logic                    w_others;
    logic                    w_timeout;
    logic [IDX_W-1:0]        w_ptr_next;

    assign w_elig = i_req_rd | i_req_wr;

    mem_port_arbiter_rr_select #(
        .N     (PORT_COUNT),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_sel_idx)
    );

    always_comb begin
        w_sel_mask              = '0;
        w_sel_mask[w_sel_idx]   = 1'b1;
        w_owner_mask            = '0;
        w_owner_mask[r_grant_idx] = 1'b1;
    end

    // A port asking for both types is served as a write.
    assign w_sel_wr = i_req_wr[w_sel_idx];

    // Only the granted request type keeps the grant; switching type releases it.
    assign w_owner_req = r_owner_wr ? i_req_wr[r_grant_idx] : i_req_rd[r_grant_idx];

    assign w_others  = |(w_elig & ~w_owner_mask);
    assign w_timeout = (r_hold == HOLD_W'(MAX_HOLD)) && w_others;

    assign w_ptr_next = (r_grant_idx == IDX_W'(PORT_COUNT - 1)) ? '0 : r_grant_idx + 1'b1;

    // r_hold counts granted cycles: 1 in the first granted cycle, saturating at
    // MAX_HOLD, so a contested owner keeps the port for exactly MAX_HOLD cycles.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_grant_rd  <= '0;
            r_grant_wr  <= '0;
            r_grant_idx <= '0;
            r_owner_wr  <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            unique case (r_state)
                // The gap cycle arbitrates exactly like idle; it only exists so
                // that the grant-free turnaround cycle is visible on the bus.
                StIdle, StGap: begin
                    if (w_found) begin
                        r_state     <= StGrant;
                        r_grant_idx <= w_sel_idx;
                        r_owner_wr  <= w_sel_wr;
                        r_grant_wr  <= w_sel_wr ? w_sel_mask : '0;
                        r_grant_rd  <= w_sel_wr ? '0 : w_sel_mask;
                        r_hold      <= HOLD_W'(1);
                    end else begin
                        r_state <= StIdle;
                        r_hold  <= '0;
                    end
                end
                StGrant: begin
                    if (!w_owner_req || w_timeout) begin
                        r_state    <= StGap;
                        r_grant_rd <= '0;
                        r_grant_wr <= '0;
                        r_hold     <= '0;
                        r_ptr      <= w_ptr_next;
                        // A voluntary release takes precedence over a timeout.
                        r_preempt  <= w_owner_req;
                    end else if (r_hold != HOLD_W'(MAX_HOLD)) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_grant_rd    = r_grant_rd;
    assign o_grant_wr    = r_grant_wr;
    assign o_grant_valid = |(r_grant_rd | r_grant_wr);
    assign o_grant_idx   = r_grant_idx;
    assign o_preempt     = r_preempt;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the single shared-memory access port between the processor pool's read and write requesters.
- Sits between the pool's per-processor rd/wr request vectors and shared_mem.
- Issues one registered, exclusive grant (read or write) at a time.
- Enforces a bounded hold time and a one-cycle bus-turnaround gap between owners.

Parameters:
- PORT_COUNT, 4, number of requesting processors (`PROC_COUNT at instantiation).
- MAX_HOLD, 16, cycles an owner may keep a grant while another port is requesting; range 2..255.
- IDX_W, $clog2(PORT_COUNT), width of the owner index.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_req_rd  input  PORT_COUNT  per-port read request, level, held until done.
- i_req_wr  input  PORT_COUNT  per-port write request, level, held until done.
- o_grant_rd  output  PORT_COUNT  one-hot read grant, registered.
- o_grant_wr  output  PORT_COUNT  one-hot write grant, registered.
- o_grant_valid  output  1  any grant active.
- o_grant_idx  output  IDX_W  current owner index; valid only when o_grant_valid.
- o_preempt  output  1  one-cycle pulse when a grant is removed by hold timeout.

Behaviour:
- Reset (async): o_grant_rd=0, o_grant_wr=0, o_grant_valid=0, o_grant_idx=0, o_preempt=0, rr pointer=0, hold counter=0, state IDLE.
- Eligibility: port p is eligible if i_req_rd[p] | i_req_wr[p]. If both are set, the write is granted for that port.
- Selection: first eligible port scanning from pointer upward, wrapping modulo PORT_COUNT.
- State IDLE:
  - If any port is eligible in cycle N, the grant is asserted in cycle N+1; go to GRANT.
  - Hold counter clears to 0.
- State GRANT:
  - The grant holds while the owner's granted request type stays high.
  - Hold counter increments each cycle and saturates at MAX_HOLD.
- Release:
  - Triggered when the owner's granted request type is sampled low in cycle N.
  - Grant is deasserted in cycle N+1; pointer = (owner+1) mod PORT_COUNT; go to GAP.
- Type switch: owner drops rd and raises wr in the same cycle -> treated as a release. The owner re-arbitrates normally and gets no priority.
- Preemption:
  - Condition: hold counter == MAX_HOLD and any other port is eligible.
  - Grant is deasserted next cycle with o_preempt=1 for that one cycle; pointer = owner+1; go to GAP.
  - If no other port is eligible, the grant is kept indefinitely.
- State GAP: exactly one cycle with all grants 0, then IDLE-equivalent selection. Minimum latency from release to the next grant is 2 cycles.
- Exclusivity invariant: popcount(o_grant_rd | o_grant_wr) <= 1 every cycle. o_grant_valid equals that OR-reduction.
- Requests that drop before being granted are ignored; no request memory.
- Reset mid-grant: grants clear immediately (async) and the pointer returns to 0.
- PORT_COUNT=1: the pointer is constant and preemption never fires.

Decomposition:
- Shared package: arbiter state enum (IDLE, GRANT, GAP) and a default-hold constant next to `PROC_COUNT / `BUS_W.
- Sub-module rr_select: combinational priority scan from a pointer, returning a found flag and index. It is reusable by the issuer's processor search.

Test Plan:
- Single requester: i_req_rd=4'b0100 at cycle 0 -> o_grant_rd=4'b0100 and o_grant_idx=2 at cycle 1. Drop req at cycle 5 -> grant 0 at cycle 6. Next grant no earlier than cycle 7.
- Round-robin: i_req_wr=4'b1111 held constant, each owner releasing after 3 granted cycles -> grant order 0,1,2,3,0 with a 1-cycle gap between each.
- Both types on one port: i_req_rd[1]=i_req_wr[1]=1 -> o_grant_wr=4'b0010, o_grant_rd=0.
- Preemption: port 0 holds rd; port 3 requests at cycle 2 -> port 0 grant drops after 16 granted cycles, o_preempt pulses once, port 3 granted after the gap. Repeat with no competitor -> port 0 keeps the grant for 40 cycles with no preempt.
- Async reset asserted mid-grant (between clock edges) -> all grants 0 immediately. After release with i_req_rd=4'b0011, port 0 is granted first (pointer=0).
- Randomized rd/wr requests over 10k cycles -> exclusivity invariant never violated, and every continuously requesting port is granted within PORT_COUNT*(MAX_HOLD+2) cycles.
